paralelo_serial_param: RTL and testbench
========================================

# paralelo_serial_param

Parametrised parallel-to-serial converter for the physical-layer transmit path, successor to the fixed 8-bit serializer. It runs on the single bit-rate clock and accepts WIDTH-bit words through a valid/ready handshake into a one-entry holding register. It shifts each word out one bit per clock, MSB- or LSB-first, and inserts the IDLE symbol (default K28.5 0xBC) whenever no word is pending. Framing outputs mark word boundaries and idle words for the downstream serial-parallel receiver and the bench.

## Interface
- WIDTH, 8: word width in bits; legal range ≥ 2.
- IDLE_WORD, 8'hBC: symbol sent when no data is pending; WIDTH bits wide.
- MSB_FIRST, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- clk_32f  input  1  bit-rate clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- valid_in  input  1  data_in holds a word to send.
- data_in  input  WIDTH  parallel word.
- ready_out  output  1  block accepts data_in this cycle.
- data_out  output  1  serial bit, registered.
- word_start  output  1  high on the clock where data_out carries the first bit of a word.
- idle_out  output  1  current word on data_out is IDLE_WORD inserted by the block, not user data.

## Operation
- Accept: a word is accepted on a posedge where valid_in && ready_out. It goes into the holding register (hold, hold_full). There is no bypass into the shifter.
- ready_out = !hold_full || boundary, combinational. A word can be accepted on the same cycle the held word drains.
- bit_cnt counts 0..WIDTH-1 and is $clog2(WIDTH) bits wide. It wraps to 0 on every load.
- boundary = (bit_cnt == WIDTH-1) || first. The first flag is set by reset and cleared on the first posedge after reset releases.
- On a boundary posedge:
  - Source word W = hold if hold_full, else IDLE_WORD.
  - Shift register <= W; data_out <= first bit of W; bit_cnt <= 0; word_start <= 1; idle_out <= !hold_full.
  - hold_full <= 1 if a new accept happens on this cycle, else 0.
- On a non-boundary posedge:
  - data_out <= next bit of the shift register per MSB_FIRST.
  - bit_cnt increments; word_start <= 0; idle_out holds its value.
  - hold_full <= 1 on an accept.
- Back-pressure: while hold_full && !boundary, ready_out = 0. valid_in/data_in must stay stable until accepted; data_in changing while unaccepted is not sampled.
- Reset asserted mid-word: all state clears immediately. The word being shifted and the held word are discarded; no partial word resumes.

## Timing
- Reset values: data_out=0, word_start=0, idle_out=1, bit_cnt=0, hold_full=0, first=1. ready_out=1, since hold is empty.
- First posedge after reset release is a boundary. IDLE_WORD starts unless a word was accepted on that same edge, which still goes out one word later.
- Latency: a word accepted on edge t appears on data_out at the first boundary edge after t. Worst case is WIDTH cycles.
- Throughput: one word per WIDTH clocks, sustained with valid_in held high. No idle gaps once the first word is held.
- Line rate: every WIDTH clocks exactly one word_start pulse, one clock wide, regardless of data.

## Structure
- Shared include paralelo_serial_defs.vh holds:
  - the IDLE default `PS_IDLE_K285 = 8'hBC`;
  - the MSB/LSB mode constants, shared with the serial_paralelo receiver.
- One sub-module, paralelo_serial_hold: the one-entry holding register and the ready_out logic.
- Shifter, counter and framing flags stay in the top module.
- Bench: probador_paralelo_serial_param, instantiated alongside the synthesized netlist for output comparison in the same way as the existing serializer bench.

## Test plan
- Reset release with valid_in=0, WIDTH=8, MSB_FIRST=1:
  - data_out repeats 1,0,1,1,1,1,0,0 (0xBC);
  - word_start every 8th clock; idle_out=1 throughout.
- Single accept of 0xCC after reset:
  - the next boundary sends 1,1,0,0,1,1,0,0 with idle_out=0;
  - IDLE_WORD resumes afterwards.
- valid_in held high with 0xCC, 0xAA, 0xCC, 0xAA:
  - back-to-back words with no idle between;
  - ready_out low 7 of 8 clocks, high on each boundary.
- MSB_FIRST=0 with 0xCC: data_out sends 0,0,1,1,0,0,1,1.
- WIDTH=10, IDLE_WORD=10'h17C:
  - word_start period is 10 clocks;
  - a 10'h2AA accept serializes correctly; bit_cnt wraps at 9.
- Reset pulled low on bit 3 of 0xAA with 0xCC held:
  - outputs go to reset values asynchronously, before the next edge;
  - after release, IDLE_WORD is sent and neither 0xAA nor 0xCC is ever sent.

Source files
------------

// File: rtl/paralelo_serial_param_pkg.sv
// Constants shared by the parallel-to-serial transmitter and the serial-to-parallel receiver.
// Bit-order modes and the default K28.5 idle symbol live here so both ends agree.
package paralelo_serial_param_pkg;

    localparam logic [7:0] PS_IDLE_K285 = 8'hBC;
    localparam int         PS_MIN_WIDTH = 2;

    typedef enum logic {
        PS_LSB_FIRST = 1'b0,
        PS_MSB_FIRST = 1'b1
    } ps_order_e;

    // Bit-counter width for a given word width (WIDTH >= 2 keeps this >= 1).
    function automatic int ps_cnt_w(input int width);
        return (width < PS_MIN_WIDTH) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/paralelo_serial_hold.sv
// One-entry holding register in front of the shifter, with the valid/ready handshake.
// A held word may be replaced on the same edge it drains into the shifter.
module paralelo_serial_hold
    import paralelo_serial_param_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_boundary,
    output logic             o_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;

    assign o_ready  = !r_full || i_boundary;
    assign w_accept = i_valid && o_ready;
    assign o_full   = r_full;
    assign o_data   = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
        end else if (i_boundary) begin
            r_full <= 1'b0;
        end
    end

    // Payload carries no reset; r_full alone says whether it is meaningful.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parametrised parallel-to-serial converter: one WIDTH-bit word per WIDTH clocks,
// idle symbol inserted whenever no word is held, with word_start/idle_out framing.
module paralelo_serial_param
    import paralelo_serial_param_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(PS_IDLE_K285),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             word_start,
    output logic             idle_out
);

    localparam int               CNT_W = ps_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam ps_order_e        ORDER = MSB_FIRST ? PS_MSB_FIRST : PS_LSB_FIRST;

    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_first;

    logic             w_boundary;
    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_next;

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (ORDER == PS_MSB_FIRST) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (ORDER == PS_MSB_FIRST) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // The edge right after reset release is a boundary even though the counter is at 0.
    assign w_boundary = (r_bit_cnt == LAST) || r_first;
    assign w_src      = w_hold_full ? w_hold_data : IDLE_WORD;
    assign w_next     = advance(r_sreg);

    paralelo_serial_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .i_clk      (clk_32f),
        .i_rst_n    (reset),
        .i_valid    (valid_in),
        .i_data     (data_in),
        .i_boundary (w_boundary),
        .o_ready    (ready_out),
        .o_full     (w_hold_full),
        .o_data     (w_hold_data)
    );

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_first    <= 1'b1;
            r_bit_cnt  <= '0;
            data_out   <= 1'b0;
            word_start <= 1'b0;
            idle_out   <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_boundary) begin
                r_bit_cnt  <= '0;
                data_out   <= lead_bit(w_src);
                word_start <= 1'b1;
                idle_out   <= !w_hold_full;
            end else begin
                r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                data_out   <= lead_bit(w_next);
                word_start <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        r_sreg <= w_boundary ? w_src : w_next;
    end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: three lanes (8b MSB-first, 8b LSB-first, 10b MSB-first)
// checked bit by bit against a word-level line model.
module tb_paralelo_serial_param;
    import paralelo_serial_param_pkg::*;

    localparam int NL = 3;

    logic          clk_32f = 1'b0;
    logic          reset   = 1'b0;
    logic [NL-1:0] valid_in;
    logic [NL-1:0] ready_out, data_out, word_start, idle_out;
    logic [7:0]    d0, d1;
    logic [9:0]    d2;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1)) u_msb8 (
        .clk_32f(clk_32f), .reset(reset), .valid_in(valid_in[0]), .data_in(d0),
        .ready_out(ready_out[0]), .data_out(data_out[0]), .word_start(word_start[0]),
        .idle_out(idle_out[0]));

    paralelo_serial_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk_32f(clk_32f), .reset(reset), .valid_in(valid_in[1]), .data_in(d1),
        .ready_out(ready_out[1]), .data_out(data_out[1]), .word_start(word_start[1]),
        .idle_out(idle_out[1]));

    paralelo_serial_param #(.WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b1)) u_msb10 (
        .clk_32f(clk_32f), .reset(reset), .valid_in(valid_in[2]), .data_in(d2),
        .ready_out(ready_out[2]), .data_out(data_out[2]), .word_start(word_start[2]),
        .idle_out(idle_out[2]));

    int          lw    [NL] = '{8, 8, 10};
    bit          lmsb  [NL] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] lidle [NL] = '{16'h00BC, 16'h00BC, 16'h017C};

    // Line model: edge count since release, one pending word, the word on the line.
    int          n        [NL];
    bit          has_pend [NL];
    logic [15:0] pend     [NL];
    logic [15:0] cur      [NL];
    bit          cur_idle [NL];

    // Stimulus: per-lane word FIFO plus the currently offered word.
    logic [15:0] fq [NL][16];
    int          fh [NL];
    int          ft [NL];
    bit          lvalid [NL];
    logic [15:0] ldata  [NL];
    bit          rnd_mode;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lane_mask(input int i);
        return 16'((32'd1 << lw[i]) - 1);
    endfunction

    task automatic drive();
        for (int i = 0; i < NL; i++) valid_in[i] = lvalid[i];
        d0 = ldata[0][7:0];
        d1 = ldata[1][7:0];
        d2 = ldata[2][9:0];
    endtask

    task automatic push(input int i, input logic [15:0] w);
        fq[i][ft[i]] = w & lane_mask(i);
        ft[i] = (ft[i] + 1) % 16;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            n[i] = 0; has_pend[i] = 1'b0; cur_idle[i] = 1'b1;
            lvalid[i] = 1'b0; ldata[i] = '0; fh[i] = 0; ft[i] = 0;
        end
        drive();
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("%s_l%0d_dout", tag, i), 32'(data_out[i]), 32'd0);
            chk($sformatf("%s_l%0d_ws", tag, i), 32'(word_start[i]), 32'd0);
            chk($sformatf("%s_l%0d_idle", tag, i), 32'(idle_out[i]), 32'd1);
            chk($sformatf("%s_l%0d_rdy", tag, i), 32'(ready_out[i]), 32'd1);
        end
    endtask

    // One clock: offer inputs after negedge, check ready, then check the edge's outputs.
    task automatic step();
        bit acc [NL];
        int pos;
        logic eb;
        for (int i = 0; i < NL; i++) begin
            if (!lvalid[i]) begin
                if (fh[i] != ft[i]) begin
                    lvalid[i] = 1'b1; ldata[i] = fq[i][fh[i]]; fh[i] = (fh[i] + 1) % 16;
                end else if (rnd_mode && $urandom_range(0, 2) == 0) begin
                    lvalid[i] = 1'b1; ldata[i] = 16'($urandom) & lane_mask(i);
                end
            end else if (rnd_mode && $urandom_range(0, 1) == 0) begin
                ldata[i] = ldata[i];
            end
        end
        drive();
        #1;
        for (int i = 0; i < NL; i++) begin
            bit exp_rdy;
            exp_rdy = !has_pend[i] || (n[i] % lw[i] == 0);
            chk($sformatf("l%0d_rdy", i), 32'(ready_out[i]), 32'(exp_rdy));
            acc[i] = lvalid[i] && exp_rdy;
        end
        @(posedge clk_32f);
        #1;
        for (int i = 0; i < NL; i++) begin
            pos = n[i] % lw[i];
            if (pos == 0) begin
                cur[i]      = has_pend[i] ? pend[i] : lidle[i];
                cur_idle[i] = !has_pend[i];
                has_pend[i] = 1'b0;
            end
            if (acc[i]) begin
                has_pend[i] = 1'b1;
                pend[i]     = ldata[i];
                lvalid[i]   = 1'b0;
            end
            eb = lmsb[i] ? cur[i][lw[i] - 1 - pos] : cur[i][pos];
            chk($sformatf("l%0d_dout", i), 32'(data_out[i]), 32'(eb));
            chk($sformatf("l%0d_ws", i), 32'(word_start[i]), 32'(pos == 0));
            chk($sformatf("l%0d_idle", i), 32'(idle_out[i]), 32'(cur_idle[i]));
            n[i]++;
        end
        @(negedge clk_32f);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    initial begin
        rnd_mode = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_32f);
        chk_reset_vals("rst");
        reset = 1'b1;

        // Idle line after release.
        repeat (24) step();

        // Single word, then idle resumes.
        push(0, 16'h00CC); push(1, 16'h00CC); push(2, 16'h02AA);
        repeat (40) step();

        // Back-to-back words with valid held high.
        push(0, 16'h00CC); push(0, 16'h00AA); push(0, 16'h00CC); push(0, 16'h00AA);
        push(1, 16'h00CC); push(1, 16'h00AA); push(1, 16'h00CC); push(1, 16'h00AA);
        push(2, 16'h02AA); push(2, 16'h0155); push(2, 16'h03FF); push(2, 16'h0000);
        repeat (50) step();

        // Reset mid-word: 0xAA on the line at bit 3, 0xCC held.
        reset = 1'b0;
        model_reset();
        release_reset();
        push(0, 16'h00AA); push(0, 16'h00CC);
        push(1, 16'h00AA); push(1, 16'h00CC);
        push(2, 16'h02AA); push(2, 16'h0133);
        for (int k = 0; k < 100 && n[0] < 12; k++) step();
        chk("mid_idle_before", 32'(idle_out[0]), 32'd0);
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        release_reset();
        repeat (40) step();

        // Randomised traffic.
        rnd_mode = 1'b1;
        repeat (600) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
